// File: rtl/branch_pred_ctrl_if.sv
// Pipeline-side signal bundle for the branch predictor: IF lookup, ID resolve and redirect.
interface branch_pred_ctrl_if;
    logic [31:0] if_pc;
    logic        if_is_branch;
    logic        if_pred_taken;
    logic        id_valid;
    logic        id_is_beq;
    logic        id_stall;
    logic [31:0] id_pc;
    logic [31:0] id_target;
    logic        id_pred_taken;
    logic        cmp_eq;
    logic        mispredict;
    logic        flush_if;
    logic [31:0] redirect_pc;

    modport master (
        output if_pc, if_is_branch, id_valid, id_is_beq, id_stall,
               id_pc, id_target, id_pred_taken, cmp_eq,
        input  if_pred_taken, mispredict, flush_if, redirect_pc
    );

    modport slave (
        input  if_pc, if_is_branch, id_valid, id_is_beq, id_stall,
               id_pc, id_target, id_pred_taken, cmp_eq,
        output if_pred_taken, mispredict, flush_if, redirect_pc
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// 2-bit saturating-counter branch predictor with ID-stage mispredict redirect.
// Optional statistics counters are enabled by defining BRANCH_PRED_STATS_EN.
module branch_pred_ctrl #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic               clk,
    input  logic               reset,
    branch_pred_ctrl_if.slave  bus
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt [DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] id_idx;
    logic             res;
    logic             mis;
    logic             unused_pc_bits;

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign id_idx = bus.id_pc[IDX_W+1:2];

    // Only the index field of the IF PC selects an entry; higher bits alias on purpose.
    assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

    // A branch resolves only on the cycle it leaves ID; reset suppresses it.
    assign res = bus.id_valid & bus.id_is_beq & ~bus.id_stall & ~reset;
    assign mis = res & (bus.cmp_eq != bus.id_pred_taken);

    assign bus.mispredict = mis;
    assign bus.flush_if   = mis;

    always_comb begin
        bus.redirect_pc = 32'd0;
        if (mis) begin
            // Not-taken fallthrough skips the always-executed delay slot.
            bus.redirect_pc = bus.cmp_eq ? bus.id_target : bus.id_pc + 32'd8;
        end
    end

    // Zero-latency read of the pre-update value; no bypass from the ID write.
    assign bus.if_pred_taken = bus.if_is_branch & (reset ? CNT_INIT[1] : cnt[if_idx][1]);

    // NOTE: the table is a flop array, not a RAM, so every entry can be reset in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= CNT_INIT;
            end
        end else if (res) begin
            if (bus.cmp_eq && cnt[id_idx] != 2'b11) begin
                cnt[id_idx] <= cnt[id_idx] + 2'd1;
            end else if (!bus.cmp_eq && cnt[id_idx] != 2'b00) begin
                cnt[id_idx] <= cnt[id_idx] - 2'd1;
            end
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (res) stat_branches    <= stat_branches + 32'd1;
            if (mis) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed scenarios plus randomized traffic
// against an integer-array reference model of the counter table.
module tb_branch_pred_ctrl;

    localparam int         IDX_W    = 4;
    localparam logic [1:0] CNT_INIT = 2'b01;
    localparam int         DEPTH    = 1 << IDX_W;

    logic clk;
    logic reset;

    branch_pred_ctrl_if bus ();

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_pred_ctrl #(.IDX_W(IDX_W), .CNT_INIT(CNT_INIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus.slave)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: counter value per entry and event totals.
    int          model [DEPTH];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    logic        obs_pred;
    logic        obs_mis;
    logic [31:0] obs_red;
    logic [31:0] obs_br;
    logic [31:0] obs_smis;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input logic rst, input logic [31:0] ipc, input logic ibr,
                         input logic v, input logic beq, input logic st,
                         input logic [31:0] dpc, input logic [31:0] tgt,
                         input logic pt, input logic ceq);
        bit          r;
        bit          e_mis;
        logic        e_pred;
        logic [31:0] e_red;
        int          ii;
        int          di;
        reset             = rst;
        bus.if_pc         = ipc;
        bus.if_is_branch  = ibr;
        bus.id_valid      = v;
        bus.id_is_beq     = beq;
        bus.id_stall      = st;
        bus.id_pc         = dpc;
        bus.id_target     = tgt;
        bus.id_pred_taken = pt;
        bus.cmp_eq        = ceq;
        @(negedge clk);
        ii     = int'(ipc[IDX_W+1:2]);
        di     = int'(dpc[IDX_W+1:2]);
        e_pred = ibr && (rst ? (int'(CNT_INIT) >= 2) : (model[ii] >= 2));
        r      = v && beq && !st && !rst;
        e_mis  = r && (ceq != pt);
        e_red  = e_mis ? (ceq ? tgt : dpc + 32'd8) : 32'd0;
        obs_pred = bus.if_pred_taken;
        obs_mis  = bus.mispredict;
        obs_red  = bus.redirect_pc;
        check("if_pred_taken", {31'd0, obs_pred}, {31'd0, e_pred});
        check("mispredict", {31'd0, obs_mis}, {31'd0, e_mis});
        check("flush_if", {31'd0, bus.flush_if}, {31'd0, e_mis});
        check("redirect_pc", obs_red, e_red);
`ifdef BRANCH_PRED_STATS_EN
        obs_br   = stat_branches;
        obs_smis = stat_mispredicts;
        check("stat_branches", obs_br, m_br);
        check("stat_mispredicts", obs_smis, m_mis);
`endif
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = int'(CNT_INIT);
            m_br  = 32'd0;
            m_mis = 32'd0;
        end else if (r) begin
            if (ceq) model[di] = (model[di] < 3) ? model[di] + 1 : 3;
            else     model[di] = (model[di] > 0) ? model[di] - 1 : 0;
            m_br = m_br + 32'd1;
            if (e_mis) m_mis = m_mis + 32'd1;
        end
        #1;
    endtask

    task automatic idle_if(input logic [31:0] ipc);
        cycle(1'b0, ipc, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            idle_if(32'h3000 + 32'(i * 4));
            check(tag, {31'd0, obs_pred}, 32'd0);
        end
    endtask

    initial begin
        obs_br   = 32'd0;
        obs_smis = 32'd0;
        for (int i = 0; i < DEPTH; i++) model[i] = int'(CNT_INIT);
        m_br  = 32'd0;
        m_mis = 32'd0;

        // Reset state: every entry predicts not-taken.
        do_reset(2);
        sweep_zero("reset_sweep_pred");

        // Mispredicted taken branch, then the strengthened entry predicts taken.
        cycle(1'b0, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3004, 32'h3020, 1'b0, 1'b1);
        check("t2_mispredict", {31'd0, obs_mis}, 32'd1);
        check("t2_redirect", obs_red, 32'h3020);
        idle_if(32'h3004);
        check("t2_pred_after", {31'd0, obs_pred}, 32'd1);

        // Saturate 0x3008 at 3, then one not-taken mispredict leaves it at 2.
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3008, 32'h3100, 1'b1, 1'b1);
        cycle(1'b0, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3008, 32'h3100, 1'b1, 1'b0);
        check("t3_mispredict", {31'd0, obs_mis}, 32'd1);
        check("t3_redirect", obs_red, 32'h3010);
        idle_if(32'h3008);
        check("t3_pred_after", {31'd0, obs_pred}, 32'd1);

        // Stalled branch: silent for three cycles, resolves once on release.
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300C, 32'h3040, 1'b0, 1'b1);
            check("t4_stall_mis", {31'd0, obs_mis}, 32'd0);
        end
        cycle(1'b0, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300C, 32'h3040, 1'b0, 1'b1);
        check("t4_release_mis", {31'd0, obs_mis}, 32'd1);
        idle_if(32'h300C);
        check("t4_pred_after", {31'd0, obs_pred}, 32'd1);
`ifdef BRANCH_PRED_STATS_EN
        check("t4_stat_branches", obs_br, 32'd1);
        check("t4_stat_mispredicts", obs_smis, 32'd1);
`endif

        // Same-index read and write: IF sees the pre-update value.
        do_reset(1);
        cycle(1'b0, 32'h3004, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3004, 32'h3020, 1'b1, 1'b1);
        check("t5_same_cycle_pred", {31'd0, obs_pred}, 32'd0);
        idle_if(32'h3004);
        check("t5_next_cycle_pred", {31'd0, obs_pred}, 32'd1);

        // Reset colliding with a mispredicting resolve.
        cycle(1'b0, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3018, 32'h3080, 1'b0, 1'b1);
        cycle(1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3018, 32'h3080, 1'b0, 1'b1);
        check("t6_reset_mis", {31'd0, obs_mis}, 32'd0);
        sweep_zero("t6_sweep_pred");
`ifdef BRANCH_PRED_STATS_EN
        check("t6_stat_branches", obs_br, 32'd0);
        check("t6_stat_mispredicts", obs_smis, 32'd0);
`endif

        // Randomized traffic, including aliased PCs and occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ipc;
            logic [31:0] dpc;
            ipc = 32'h3000 + 32'($urandom_range(0, DEPTH - 1) * 4);
            dpc = 32'h3000 + 32'($urandom_range(0, DEPTH - 1) * 4);
            if ($urandom_range(0, 3) == 0) ipc[31:16] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) dpc[31:16] = 16'($urandom);
            cycle(($urandom_range(0, 59) == 0), ipc, 1'($urandom), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), dpc,
                  $urandom, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
